// File: rtl/ds18b20_pkg.sv
// Shared constants, FSM encodings and the Dallas CRC8 byte step for the
// DS18B20 read sequencer.
package ds18b20_pkg;

    // DS18B20 function/ROM command bytes
    localparam logic [7:0] CMD_SKIP_ROM     = 8'hCC;
    localparam logic [7:0] CMD_CONVERT_T    = 8'h44;
    localparam logic [7:0] CMD_READ_SCRATCH = 8'hBE;

    // Error codes reported on err
    localparam logic [1:0] ERR_NONE        = 2'd0;
    localparam logic [1:0] ERR_NO_PRESENCE = 2'd1;
    localparam logic [1:0] ERR_CRC         = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT     = 2'd3;

    // Reflected form of x^8+x^5+x^4+1
    localparam logic [7:0] CRC8_POLY = 8'h8C;

    // Top-level sequence steps
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RST1,
        ST_SKIP1,
        ST_CONV,
        ST_POLL,
        ST_RST2,
        ST_SKIP2,
        ST_RDCMD,
        ST_RDBYTE,
        ST_CHECK
    } state_e;

    // Sub-phase of every PHY step: strobe, one guard cycle, wait for idle
    typedef enum logic [1:0] {
        PH_ISSUE,
        PH_GUARD,
        PH_WAIT
    } phase_e;

    // One byte through the CRC, data bits taken LSB first
    function automatic logic [7:0] crc8_step(input logic [7:0] crc_in,
                                             input logic [7:0] din);
        logic [7:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ din[i]) begin
                c = (c >> 1) ^ CRC8_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/ds18b20_sequencer_crc8.sv
// Byte-serial Dallas CRC8 accumulator; clr wins over en.
module onewire_crc8
    import ds18b20_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] crc
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;

    // Next CRC: clear, fold one byte, or hold
    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = 8'h00;
        end else if (en) begin
            crc_d = crc8_step(crc_q, din);
        end
    end

    // CRC register
    always_ff @(posedge clk) begin
        crc_q <= crc_d;
    end

    assign crc = crc_q;

endmodule

// File: rtl/ds18b20_sequencer.sv
// DS18B20 measurement sequencer: drives the 1-Wire PHY command strobes through
// reset/presence, SKIP ROM, CONVERT T, polling, and a scratchpad read with CRC.
// Handshake: every PHY step raises exactly one strobe for one cycle, skips one
// guard cycle while the PHY raises phy_busy, then waits for phy_busy==0 and
// samples the step result (phy_error / phy_dout) in that same cycle.
module ds18b20_sequencer
    import ds18b20_pkg::*;
#(
    parameter int unsigned FREQ        = 48,
    parameter int unsigned CONV_TMO_MS = 800,
    parameter int          CRC_EN      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic [15:0] temp,
    output logic        temp_valid,
    output logic [1:0]  err,
    output logic        err_valid,
    output logic        phy_rst,
    output logic        phy_presence,
    output logic        phy_wr,
    output logic        phy_rd,
    output logic        phy_chk,
    output logic [7:0]  phy_data,
    input  logic        phy_busy,
    input  logic        phy_error,
    input  logic [7:0]  phy_dout,
    input  logic        phy_conv_done
);

    localparam int unsigned TMO_CYCLES = CONV_TMO_MS * 1000 * FREQ;
    localparam int          TMO_W      = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
    localparam logic [3:0]  LAST_BYTE  = (CRC_EN != 0) ? 4'd8 : 4'd1;

    state_e             state_q, state_d;
    phase_e             phase_q, phase_d;
    logic               busy_q, busy_d;
    logic [15:0]        temp_q, temp_d;
    logic               temp_valid_q, temp_valid_d;
    logic [1:0]         err_q, err_d;
    logic               err_valid_q, err_valid_d;
    logic               phy_rst_q, phy_rst_d;
    logic               pres_q, pres_d;
    logic               wr_q, wr_d;
    logic               rd_q, rd_d;
    logic               chk_q, chk_d;
    logic [7:0]         data_q, data_d;
    logic [3:0]         k_q, k_d;
    logic [7:0]         b0_q, b0_d;
    logic [7:0]         b1_q, b1_d;
    logic               conv_seen_q, conv_seen_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;

    logic               step_done;
    logic               crc_clr_c;
    logic               crc_en;
    logic [7:0]         crc;

    onewire_crc8 u_crc (
        .clk (clk),
        .clr (rst | crc_clr_c),
        .en  (crc_en),
        .din (phy_dout),
        .crc (crc)
    );

    // Sequencer next-state, result capture and strobe generation
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        busy_d       = busy_q;
        temp_d       = temp_q;
        temp_valid_d = 1'b0;
        err_d        = err_q;
        err_valid_d  = 1'b0;
        phy_rst_d    = 1'b0;
        pres_d       = 1'b0;
        wr_d         = 1'b0;
        rd_d         = 1'b0;
        chk_d        = 1'b0;
        data_d       = data_q;
        k_d          = k_q;
        b0_d         = b0_q;
        b1_d         = b1_q;
        conv_seen_d  = conv_seen_q;
        tmo_d        = tmo_q;
        step_done    = 1'b0;
        crc_clr_c    = 1'b0;
        crc_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A start coinciding with the done pulse is dropped
                if (start && !temp_valid_q && !err_valid_q) begin
                    state_d   = ST_RST1;
                    phase_d   = PH_ISSUE;
                    busy_d    = 1'b1;
                    k_d       = 4'd0;
                    crc_clr_c = 1'b1;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                if ((CRC_EN == 0) || (crc == 8'h00)) begin
                    temp_d       = {b1_q, b0_q};
                    temp_valid_d = 1'b1;
                end else begin
                    err_d       = ERR_CRC;
                    err_valid_d = 1'b1;
                end
            end
            default: begin
                case (phase_q)
                    PH_ISSUE: phase_d = PH_GUARD;
                    PH_GUARD: phase_d = PH_WAIT;
                    default:  step_done = !phy_busy;
                endcase

                if (step_done) begin
                    phase_d = PH_ISSUE;
                    case (state_q)
                        ST_RST1, ST_RST2: begin
                            if (phy_error) begin
                                state_d     = ST_IDLE;
                                busy_d      = 1'b0;
                                err_d       = ERR_NO_PRESENCE;
                                err_valid_d = 1'b1;
                            end else begin
                                state_d = (state_q == ST_RST1) ? ST_SKIP1 : ST_SKIP2;
                            end
                        end
                        ST_SKIP1: state_d = ST_CONV;
                        ST_CONV: begin
                            state_d     = ST_POLL;
                            tmo_d       = TMO_W'(TMO_CYCLES - 1);
                            conv_seen_d = 1'b0;
                        end
                        ST_POLL: begin
                            // Either move on or reissue another poll slot
                            if (conv_seen_q || phy_conv_done) begin
                                state_d = ST_RST2;
                            end
                            conv_seen_d = 1'b0;
                        end
                        ST_SKIP2: state_d = ST_RDCMD;
                        ST_RDCMD: begin
                            state_d = ST_RDBYTE;
                            k_d     = 4'd0;
                        end
                        ST_RDBYTE: begin
                            crc_en = 1'b1;
                            if (k_q == 4'd0) b0_d = phy_dout;
                            if (k_q == 4'd1) b1_d = phy_dout;
                            if (k_q == LAST_BYTE) begin
                                state_d = ST_CHECK;
                            end else begin
                                k_d = k_q + 4'd1;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end

                if (state_q == ST_POLL) begin
                    if (!step_done) begin
                        conv_seen_d = conv_seen_q | phy_conv_done;
                    end
                    // The PHY poll slot never ends on its own, so abort it
                    if (tmo_q == '0) begin
                        state_d     = ST_IDLE;
                        busy_d      = 1'b0;
                        err_d       = ERR_TIMEOUT;
                        err_valid_d = 1'b1;
                        phy_rst_d   = 1'b1;
                    end else begin
                        tmo_d = tmo_q - TMO_W'(1);
                    end
                end
            end
        endcase

        // Raise the strobe for a freshly entered step
        if (phase_d == PH_ISSUE && (state_d != state_q || step_done || state_q == ST_IDLE)) begin
            case (state_d)
                ST_RST1, ST_RST2: pres_d = 1'b1;
                ST_SKIP1, ST_SKIP2: begin
                    wr_d   = 1'b1;
                    data_d = CMD_SKIP_ROM;
                end
                ST_CONV: begin
                    wr_d   = 1'b1;
                    data_d = CMD_CONVERT_T;
                end
                ST_RDCMD: begin
                    wr_d   = 1'b1;
                    data_d = CMD_READ_SCRATCH;
                end
                ST_POLL:   chk_d = 1'b1;
                ST_RDBYTE: rd_d  = 1'b1;
                default: ;
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            phase_q      <= PH_ISSUE;
            busy_q       <= 1'b0;
            temp_q       <= 16'h0000;
            temp_valid_q <= 1'b0;
            err_q        <= ERR_NONE;
            err_valid_q  <= 1'b0;
            phy_rst_q    <= 1'b1;
            pres_q       <= 1'b0;
            wr_q         <= 1'b0;
            rd_q         <= 1'b0;
            chk_q        <= 1'b0;
            data_q       <= 8'h00;
            k_q          <= 4'd0;
            b0_q         <= 8'h00;
            b1_q         <= 8'h00;
            conv_seen_q  <= 1'b0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            busy_q       <= busy_d;
            temp_q       <= temp_d;
            temp_valid_q <= temp_valid_d;
            err_q        <= err_d;
            err_valid_q  <= err_valid_d;
            phy_rst_q    <= phy_rst_d;
            pres_q       <= pres_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            chk_q        <= chk_d;
            data_q       <= data_d;
            k_q          <= k_d;
            b0_q         <= b0_d;
            b1_q         <= b1_d;
            conv_seen_q  <= conv_seen_d;
            tmo_q        <= tmo_d;
        end
    end

    assign busy         = busy_q;
    assign temp         = temp_q;
    assign temp_valid   = temp_valid_q;
    assign err          = err_q;
    assign err_valid    = err_valid_q;
    assign phy_rst      = phy_rst_q;
    assign phy_presence = pres_q;
    assign phy_wr       = wr_q;
    assign phy_rd       = rd_q;
    assign phy_chk      = chk_q;
    assign phy_data     = data_q;

endmodule

// File: tb/tb_ds18b20_sequencer.sv
// Directed bench for ds18b20_sequencer with a behavioural PHY responder and
// scoreboards for command bytes and measurement results.
module tb_ds18b20_sequencer;

    localparam int unsigned FREQ        = 1;
    localparam int unsigned CONV_TMO_MS = 1;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic [15:0] temp;
    logic        temp_valid;
    logic [1:0]  err;
    logic        err_valid;
    logic        phy_rst;
    logic        phy_presence;
    logic        phy_wr;
    logic        phy_rd;
    logic        phy_chk;
    logic [7:0]  phy_data;
    logic        phy_busy;
    logic        phy_error;
    logic [7:0]  phy_dout;
    logic        phy_conv_done;

    ds18b20_sequencer #(
        .FREQ        (FREQ),
        .CONV_TMO_MS (CONV_TMO_MS),
        .CRC_EN      (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .busy          (busy),
        .temp          (temp),
        .temp_valid    (temp_valid),
        .err           (err),
        .err_valid     (err_valid),
        .phy_rst       (phy_rst),
        .phy_presence  (phy_presence),
        .phy_wr        (phy_wr),
        .phy_rd        (phy_rd),
        .phy_chk       (phy_chk),
        .phy_data      (phy_data),
        .phy_busy      (phy_busy),
        .phy_error     (phy_error),
        .phy_dout      (phy_dout),
        .phy_conv_done (phy_conv_done)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;

    logic [17:0] exp_q[$];     // {err, temp} expected at each done pulse
    logic [7:0]  exp_wr_q[$];  // expected command bytes in order

    logic [7:0]  scratch [9];
    bit          cfg_no_dev;
    int          cfg_conv_after;   // 0: conversion never completes
    int          n_wr, n_rd, n_chk, n_pres;
    int          first_chk_cyc;
    int          phy_rst_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_crc8(input logic [7:0] bytes [9], input int n);
        logic [7:0] c;
        logic [7:0] b;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            b = bytes[i];
            for (int j = 0; j < 8; j++) begin
                if ((c[0] ^ b[0]) != 1'b0) c = {1'b0, c[7:1]} ^ 8'h8C;
                else                       c = {1'b0, c[7:1]};
                b = {1'b0, b[7:1]};
            end
        end
        return c;
    endfunction

    // ---------------- PHY responder ----------------
    initial begin : phy_model
        int  lat;
        int  op;          // 1 presence, 2 write, 3 read, 4 poll
        int  rd_idx;
        int  poll_num;
        bit  dout_live;
        phy_busy      = 1'b0;
        phy_error     = 1'b0;
        phy_dout      = 8'h00;
        phy_conv_done = 1'b0;
        lat = 0; op = 0; rd_idx = 0; poll_num = 0; dout_live = 0;
        forever begin
            @(negedge clk);
            phy_conv_done = 1'b0;
            if (dout_live) begin
                phy_dout  = 8'($urandom);
                dout_live = 0;
            end
            if (rst || phy_rst) begin
                phy_busy = 1'b0;
                lat      = 0;
                poll_num = 0;
            end else begin
                if (phy_busy) begin
                    lat--;
                    if (op == 4 && poll_num == cfg_conv_after && lat == 2) phy_conv_done = 1'b1;
                    if (lat == 0) begin
                        phy_busy = 1'b0;
                        if (op == 1) phy_error = cfg_no_dev;
                        if (op == 3) begin
                            phy_dout  = (rd_idx < 9) ? scratch[rd_idx] : 8'hEE;
                            rd_idx++;
                            dout_live = 1;
                        end
                    end
                end
                if (phy_presence || phy_wr || phy_rd || phy_chk) begin
                    check("strobe_onehot", $countones({phy_presence, phy_wr, phy_rd, phy_chk}), 1);
                    phy_busy = 1'b1;
                    lat      = 5;
                    if (phy_presence) begin
                        op = 1; lat = 6; n_pres++; poll_num = 0;
                    end else if (phy_wr) begin
                        op = 2; n_wr++;
                        check("wr_pending", exp_wr_q.size() != 0, 1);
                        if (exp_wr_q.size() != 0) check("wr_byte", phy_data, exp_wr_q.pop_front());
                        if (phy_data == 8'hBE) rd_idx = 0;
                    end else if (phy_rd) begin
                        op = 3; n_rd++;
                    end else begin
                        op = 4; n_chk++; poll_num++;
                        if (first_chk_cyc < 0) first_chk_cyc = cyc;
                        if (cfg_conv_after == 0) lat = 1000000;
                    end
                end
            end
        end
    end

    // ---------------- result monitor ----------------
    initial begin : result_monitor
        logic [17:0] obs;
        forever begin
            @(negedge clk);
            if (phy_rst && !rst) phy_rst_cyc = cyc;
            if (!rst && (temp_valid || err_valid)) begin
                check("pulse_exclusive", 32'(temp_valid & err_valid), 0);
                check("busy_low_at_done", 32'(busy), 0);
                obs = temp_valid ? {2'b00, temp} : {err, temp};
                check("result_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("result", 32'(obs), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic begin_run(input bit no_dev, input int conv_after);
        cfg_no_dev     = no_dev;
        cfg_conv_after = conv_after;
        n_wr = 0; n_rd = 0; n_chk = 0; n_pres = 0;
        first_chk_cyc  = -1;
        phy_rst_cyc    = -1;
        pulse_start();
    endtask

    task automatic push_cmds();
        exp_wr_q.push_back(8'hCC);
        exp_wr_q.push_back(8'h44);
        exp_wr_q.push_back(8'hCC);
        exp_wr_q.push_back(8'hBE);
    endtask

    task automatic set_scratch(input logic [7:0] t0, input logic [7:0] t1);
        scratch[0] = t0;    scratch[1] = t1;    scratch[2] = 8'h4B;
        scratch[3] = 8'h46; scratch[4] = 8'h7F; scratch[5] = 8'hFF;
        scratch[6] = 8'h0C; scratch[7] = 8'h10;
        scratch[8] = ref_crc8(scratch, 8);
    endtask

    // Wait for the done pulse (bounded); returns at the pulse-cycle negedge
    task automatic wait_done(input string tag, input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (temp_valid || err_valid) seen = 1;
        end
        check({tag, "_done_seen"}, 32'(seen), 1);
    endtask

    task automatic check_pulse_gone(input string tag);
        @(negedge clk);
        check({tag, "_pulse_1cyc"}, 32'(temp_valid | err_valid | phy_rst), 0);
        check({tag, "_busy_low"}, 32'(busy), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin : stimulus
        bit hit;
        rst = 1'b1;
        start = 1'b0;
        cfg_no_dev = 0;
        cfg_conv_after = 3;
        first_chk_cyc = -1;
        phy_rst_cyc = -1;
        set_scratch(8'h50, 8'h05);
        repeat (3) @(negedge clk);

        // reset values
        check("rst_busy", 32'(busy), 0);
        check("rst_temp", 32'(temp), 0);
        check("rst_err", {temp_valid, err_valid, err}, 0);
        check("rst_phy_rst", 32'(phy_rst), 1);
        check("rst_strobes", {phy_presence, phy_wr, phy_rd, phy_chk, phy_data}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("phy_rst_release", 32'(phy_rst), 0);

        // no device: presence error, no writes
        exp_q.push_back({2'd1, 16'h0000});
        begin_run(1, 3);
        check("busy_after_start", 32'(busy), 1);
        wait_done("nodev", 500);
        check("nodev_no_wr", n_wr, 0);
        check_pulse_gone("nodev");

        // 85.0C power-on scratchpad, conversion on third poll; extra start while busy
        set_scratch(8'h50, 8'h05);
        scratch[8] = 8'h1C;
        push_cmds();
        exp_q.push_back({2'd0, 16'h0550});
        begin_run(0, 3);
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("good", 3000);
        check("good_polls", n_chk, 3);
        check("good_reads", n_rd, 9);
        check("good_presence", n_pres, 2);
        // start on the done cycle must be ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_at_done_ignored", 32'(busy), 0);
        repeat (3) @(negedge clk);
        check("still_idle", 32'(busy), 0);

        // corrupted CRC byte: err=2, temp holds
        scratch[8] = 8'h1D;
        push_cmds();
        exp_q.push_back({2'd2, 16'h0550});
        begin_run(0, 1);
        wait_done("badcrc", 3000);
        check_pulse_gone("badcrc");
        check("badcrc_temp_hold", 32'(temp), 32'h0550);

        // negative temperature -10.125C
        set_scratch(8'h5E, 8'hFF);
        push_cmds();
        exp_q.push_back({2'd0, 16'hFF5E});
        begin_run(0, 2);
        wait_done("neg", 3000);
        check_pulse_gone("neg");

        // conversion never completes: abort after the poll budget
        exp_wr_q.push_back(8'hCC);
        exp_wr_q.push_back(8'h44);
        exp_q.push_back({2'd3, 16'hFF5E});
        begin_run(0, 0);
        wait_done("tmo", 3000);
        check("tmo_phy_rst_now", 32'(phy_rst), 1);
        check("tmo_latency", phy_rst_cyc - first_chk_cyc, 1000);
        check_pulse_gone("tmo");

        // rst in the middle of the scratchpad read
        set_scratch(8'h91, 8'h01);
        push_cmds();
        begin_run(0, 1);
        hit = 0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            @(negedge clk);
            if (n_rd == 5) hit = 1;
        end
        check("reached_rdbyte4", 32'(hit), 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_phy_rst", 32'(phy_rst), 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_temp_cleared", {busy, temp_valid, err_valid, err, temp}, 0);
        check("midrst_wr_drained", exp_wr_q.size(), 0);

        // clean full sequence afterwards
        set_scratch(8'h91, 8'h01);
        push_cmds();
        exp_q.push_back({2'd0, 16'h0191});
        begin_run(0, 2);
        wait_done("after_rst", 3000);
        check("after_rst_reads", n_rd, 9);
        check_pulse_gone("after_rst");

        repeat (5) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        check("exp_wr_q_empty", exp_wr_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
